core_sequencer: RTL and testbench
=================================

// Module: core_sequencer
//
// PURPOSE
//   Multi-cycle control FSM for the single-issue core. Fetches one instruction
//   at a time over a req/ack port and holds it stable for the registered
//   immediate generator. Sequences decode/execute/writeback enables and owns
//   the PC: JAL -> PC+imm, OP-IMM -> PC+4. Any other opcode halts the core.
//
// PARAMETERS
//   RESET_PC   32'h0000_0000  PC value loaded on reset
//   XLEN       32             data/address width; only 32 is supported
//
// PORTS
//   clk         in   1     core clock; all state updates on posedge
//   rst_n       in   1     synchronous active-low reset
//   imem_req    out  1     fetch request; held high until imem_ack
//   imem_addr   out  32    fetch address (= pc while imem_req)
//   imem_ack    in   1     imem_rdata valid this cycle; ignored unless imem_req
//   imem_rdata  in   32    fetched instruction word
//   inst        out  32    latched instruction, to immgen and decode
//   imm         in   32    immgen output, valid from the cycle after DECODE
//   alu_en      out  1     one-cycle execute strobe (EXEC state)
//   rf_we       out  1     register-file write strobe (WB state, rd!=0)
//   rf_wsel     out  1     WB source: 0 = ALU result, 1 = pc+4 (JAL link)
//   pc          out  32    current PC
//   halted      out  1     sticky; set on unsupported opcode
//
// BEHAVIOUR
//   - Reset (rst_n==0 at posedge): state=FETCH, pc=RESET_PC, inst=32'h0000_0013
//     (NOP), imem_req=0, alu_en=0, rf_we=0, rf_wsel=0, halted=0. Reset
//     mid-fetch drops imem_req the same edge; a late ack is ignored.
//   - States: FETCH -> WAIT -> DECODE -> EXEC -> WB -> FETCH; HALT is absorbing.
//   - FETCH: registers imem_req=1, imem_addr=pc; -> WAIT (1 cycle).
//   - WAIT: hold req/addr stable. On imem_ack: inst<=imem_rdata, imem_req<=0,
//     -> DECODE. No timeout; a wait of any length is legal.
//   - DECODE (1 cycle): classify inst[6:2]. Value 5'b00100 (OP-IMM) or
//     5'b11011 (JAL) -> EXEC. Any other value -> HALT with halted<=1, pc frozen.
//     inst[1:0]!=2'b11 also halts. The registered immgen output is valid
//     after this edge.
//   - EXEC: alu_en=1 for exactly one cycle; -> WB.
//   - WB: rf_we=1 when inst[11:7]!=0. rf_wsel=1 for JAL, else 0.
//     pc<=pc+imm (JAL) or pc+4 (OP-IMM), modulo 2^32 wrap with no flag; -> FETCH.
//   - Minimum latency: 5 cycles per instruction with a 0-wait ack
//     (ack in the first WAIT cycle).
//   - A JAL target with imm[1]!=0 (misaligned) -> HALT instead of WB update;
//     rf_we stays 0.
//   - inst is stable except at the WAIT->DECODE edge.
//   - alu_en and rf_we are never high in the same cycle.
//
// CONFIGURATION
//   CORE_SEQ_PERF_EN defined: adds outputs retired_cnt[31:0] and
//     stall_cnt[31:0], both reset to 0. retired_cnt increments on each
//     WB->FETCH edge. stall_cnt increments on each WAIT cycle without ack.
//     Both wrap at 2^32.
//   Not defined: neither port nor counter exists; the rest is identical.
//
// TESTING
//   1. Reset with RESET_PC=0, ack always 1 -> first imem_req at cycle 1,
//      addr 0x0; halted=0.
//   2. Fetch 0x00500093 (addi x1,x0,5) -> alu_en one cycle; then rf_we=1 with
//      rf_wsel=0; pc 0x0->0x4; next fetch 5 cycles after the first.
//   3. Fetch 0x008000EF (jal x1,8) at pc=0x4 -> rf_we=1 with rf_wsel=1;
//      pc=0xC; next imem_addr=0xC.
//   4. Hold imem_ack low for 7 cycles in WAIT -> imem_req/imem_addr stable for
//      all 7 cycles; stall_cnt=7 when CORE_SEQ_PERF_EN is defined.
//   5. Fetch 0x00000033 (OP, unsupported) -> halted=1 after DECODE; no
//      alu_en/rf_we; imem_req stays 0 for 20 cycles; rst_n=0 clears halted.
//   6. Assert rst_n=0 during WAIT while ack arrives the same cycle -> inst stays
//      NOP, pc=RESET_PC, fetch restarts cleanly.

Source files
------------

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle fetch/decode/exec/writeback control FSM for the
// single-issue core. Owns the PC and the latched instruction word.
// Optional build macro: CORE_SEQ_PERF_EN adds retired_cnt / stall_cnt counters.
module core_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] inst,
  input  logic [XLEN-1:0] imm,
  output logic            alu_en,
  output logic            rf_we,
  output logic            rf_wsel,
  output logic [XLEN-1:0] pc,
  output logic            halted
`ifdef CORE_SEQ_PERF_EN
  ,
  output logic [31:0]     retired_cnt,
  output logic [31:0]     stall_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  state_t state, state_nxt;

  logic is_jal, is_opimm, legal, ack_ok;

  assign is_jal   = (inst[6:2] == 5'b11011);
  assign is_opimm = (inst[6:2] == 5'b00100);
  assign legal    = (inst[1:0] == 2'b11) && (is_jal || is_opimm);
  // an ack only counts while a request is actually outstanding
  assign ack_ok   = imem_ack && imem_req;

  // next-state and per-state strobes
  always_comb begin
    state_nxt = state;
    alu_en    = 1'b0;
    rf_we     = 1'b0;
    rf_wsel   = 1'b0;
    case (state)
      S_FETCH:  state_nxt = S_WAIT;
      S_WAIT:   if (ack_ok) state_nxt = S_DECODE;
      S_DECODE: state_nxt = legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        alu_en    = 1'b1;
        // misaligned jump target stops the core before any writeback
        state_nxt = (is_jal && imm[1]) ? S_HALT : S_WB;
      end
      S_WB: begin
        rf_we     = (inst[11:7] != 5'd0);
        rf_wsel   = is_jal;
        state_nxt = S_FETCH;
      end
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // state, fetch port, instruction latch, PC and sticky halt
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      pc        <= XLEN'(RESET_PC);
      inst      <= NOP;
      imem_req  <= 1'b0;
      imem_addr <= XLEN'(RESET_PC);
      halted    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH) begin
        imem_req  <= 1'b1;
        imem_addr <= pc;
      end
      if (state == S_WAIT && ack_ok) begin
        inst     <= imem_rdata;
        imem_req <= 1'b0;
      end
      if (state == S_WB)
        pc <= is_jal ? (pc + imm) : (pc + XLEN'(4));
      if (state != S_HALT && state_nxt == S_HALT)
        halted <= 1'b1;
    end
  end

`ifdef CORE_SEQ_PERF_EN
  // retired instructions and fetch stall cycles, free-running with wrap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_cnt <= 32'd0;
      stall_cnt   <= 32'd0;
    end else begin
      if (state == S_WB)
        retired_cnt <= retired_cnt + 32'd1;
      if (state == S_WAIT && !ack_ok)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: directed vectors for core_sequencer with hand-computed
// expectations. Build with CORE_SEQ_PERF_EN to also check the perf counters.
module tb_core_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] imm;
  logic        alu_en, rf_we, rf_wsel, halted;
  logic [31:0] pc;
`ifdef CORE_SEQ_PERF_EN
  logic [31:0] retired_cnt, stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  core_sequencer #(.RESET_PC(32'h0), .XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst       (inst),
    .imm        (imm),
    .alu_en     (alu_en),
    .rf_we      (rf_we),
    .rf_wsel    (rf_wsel),
    .pc         (pc),
    .halted     (halted)
`ifdef CORE_SEQ_PERF_EN
    ,
    .retired_cnt(retired_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // advance one cycle; sample and drive 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0; imm = 32'h0;
    tick(); tick();
    chk("rst_req",    {31'd0, imem_req}, 32'd0);
    chk("rst_pc",     pc,                32'h0);
    chk("rst_inst",   inst,              32'h0000_0013);
    chk("rst_halted", {31'd0, halted},   32'd0);
    chk("rst_strobe", {30'd0, alu_en, rf_we}, 32'd0);

    // addi x1,x0,5 at pc 0, ack always high
    rst_n = 1'b1; imem_rdata = 32'h0050_0093; imm = 32'd5;
    chk("c0_req", {31'd0, imem_req}, 32'd0);
    tick();                                         // cycle 1: WAIT
    chk("c1_req",  {31'd0, imem_req}, 32'd1);
    chk("c1_addr", imem_addr,         32'h0);
    tick();                                         // cycle 2: DECODE
    chk("c2_inst", inst,              32'h0050_0093);
    chk("c2_req",  {31'd0, imem_req}, 32'd0);
    tick();                                         // cycle 3: EXEC
    chk("c3_alu",  {31'd0, alu_en},   32'd1);
    chk("c3_we",   {31'd0, rf_we},    32'd0);
    tick();                                         // cycle 4: WB
    chk("c4_alu",  {31'd0, alu_en},   32'd0);
    chk("c4_we",   {31'd0, rf_we},    32'd1);
    chk("c4_wsel", {31'd0, rf_wsel},  32'd0);
    tick();                                         // cycle 5: FETCH
    chk("c5_pc",   pc,                32'h4);
    chk("c5_req",  {31'd0, imem_req}, 32'd0);

    // jal x1,8 at pc 4
    imem_rdata = 32'h0080_00EF; imm = 32'd8;
    tick();                                         // cycle 6: WAIT
    chk("c6_req",  {31'd0, imem_req}, 32'd1);
    chk("c6_addr", imem_addr,         32'h4);
    tick();                                         // cycle 7: DECODE
    chk("c7_inst", inst,              32'h0080_00EF);
    tick();                                         // cycle 8: EXEC
    chk("c8_alu",  {31'd0, alu_en},   32'd1);
    tick();                                         // cycle 9: WB
    chk("c9_we",   {31'd0, rf_we},    32'd1);
    chk("c9_wsel", {31'd0, rf_wsel},  32'd1);
    tick();                                         // cycle 10: FETCH
    chk("c10_pc",  pc,                32'hC);

    // stall 7 cycles in WAIT at pc 0xC, then deliver an unsupported OP
    imem_ack = 1'b0; imem_rdata = 32'h0000_0033; imm = 32'd0;
    for (int i = 0; i < 7; i++) begin
      tick();                                       // cycles 11..17
      chk("stall_req",  {31'd0, imem_req}, 32'd1);
      chk("stall_addr", imem_addr,         32'hC);
    end
    tick();                                         // cycle 18: still WAIT
    chk("c18_req", {31'd0, imem_req}, 32'd1);
`ifdef CORE_SEQ_PERF_EN
    chk("stall_cnt",   stall_cnt,   32'd7);
    chk("retired_cnt", retired_cnt, 32'd2);
`endif
    imem_ack = 1'b1;
    tick();                                         // cycle 19: DECODE
    chk("c19_inst", inst, 32'h0000_0033);
    chk("c19_alu",  {31'd0, alu_en}, 32'd0);
    tick();                                         // cycle 20: HALT
    chk("halt_set", {31'd0, halted}, 32'd1);
    chk("halt_pc",  pc,              32'hC);
    for (int i = 0; i < 20; i++) begin
      chk("halt_quiet", {29'd0, imem_req, alu_en, rf_we}, 32'd0);
      tick();
    end
    chk("halt_sticky", {31'd0, halted}, 32'd1);

    // reset clears halt
    rst_n = 1'b0;
    tick();
    chk("rst2_halted", {31'd0, halted}, 32'd0);
    chk("rst2_pc",     pc,              32'h0);

    // reset lands in WAIT together with an ack: fetched word must be dropped
    rst_n = 1'b1; imem_ack = 1'b0;
    tick();                                         // WAIT
    chk("w_req", {31'd0, imem_req}, 32'd1);
    rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
    tick();
    chk("wr_req",  {31'd0, imem_req}, 32'd0);
    chk("wr_inst", inst,              32'h0000_0013);
    chk("wr_pc",   pc,                32'h0);

    // clean restart, misaligned jal x1,6 -> halt with no writeback
    rst_n = 1'b1; imem_rdata = 32'h0060_00EF; imm = 32'd6;
    tick();                                         // WAIT
    chk("rs_req",  {31'd0, imem_req}, 32'd1);
    chk("rs_addr", imem_addr,         32'h0);
    tick();                                         // DECODE
    chk("rs_inst", inst,              32'h0060_00EF);
    tick();                                         // EXEC
    chk("mj_alu",  {31'd0, alu_en},   32'd1);
    tick();                                         // HALT
    chk("mj_halt", {31'd0, halted},   32'd1);
    chk("mj_we",   {31'd0, rf_we},    32'd0);
    chk("mj_pc",   pc,                32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
